mac_tile_mw: RTL and testbench
==============================

// Module: mac_tile_mw
// PURPOSE
//  Next-gen systolic PE: parametrised successor of the single-weight MAC tile. Holds NW weight slots,
//  time-multiplexed across execute cycles, and runs weight-stationary (WS: psum flows north->south)
//  or output-stationary (OS: psum accumulates locally, drained on command). Zero-operand gating and
//  optional saturation. Tiled in a 2-D array: activations/instructions flow west->east, psums north->south.
// PARAMETERS
//  BW       4   activation/weight width (act unsigned, weight signed two's complement)
//  PSUM_BW  16  partial-sum width (signed)
//  NW       4   weight slots per tile (>=1, power of 2)
//  SAT      0   1: psum add saturates to PSUM_BW signed range; 0: wraps mod 2^PSUM_BW
// PORTS
//  clk       in   1        clock
//  reset     in   1        synchronous, active-high
//  os_mode   in   1        0=WS, 1=OS; static while any inst bit is active
//  in_w      in   BW       activation (exec) or weight (load) from west
//  inst_w    in   3        [0]=load weight, [1]=execute, [2]=drain (OS only)
//  in_n      in   PSUM_BW  psum from north
//  out_e     out  BW       registered in_w to east
//  inst_e    out  3        registered/filtered inst to east
//  out_s     out  PSUM_BW  psum to south
//  out_s_vld out  1        out_s holds a new result this cycle
//  zskip     out  1        last execute was zero-gated (perf counter tap)
// BEHAVIOUR
//  Reset: a_q, all weight slots, acc, out_s, wptr, rptr = 0; inst_e = 0; out_s_vld = 0; zskip = 0; FSM=FILL.
//  Load FSM (FILL, FULL):
//   FILL: inst_w[0]=1 -> w[wptr] <= in_w, wptr++; on wptr==NW-1 write go FULL. inst_e[0] forced 0.
//   FULL: no weight writes; inst_e[0] <= inst_w[0] (forwards loads to east tiles).
//   FULL + rising edge of inst_w[0] (was 0 prev cycle) -> FILL, wptr=0, that cycle's word written to w[0].
//  out_e <= in_w when inst_w[0]|inst_w[1], else holds. inst_e[2:1] <= inst_w[2:1] always. Latency 1 cycle.
//  Execute (inst_w[1]=1): operand w = w[rptr]; rptr++ (wraps NW-1 -> 0); rptr reset to 0 on FILL entry.
//   prod = $signed({1'b0,in_w}) * $signed(w), 2*BW+1 bits, sign-extended to PSUM_BW.
//   in_w==0 or w==0 -> multiplier inputs held, prod=0, zskip<=1; otherwise zskip<=0.
//   WS: out_s <= in_n + prod; out_s_vld <= 1. Non-exec cycle: out_s <= in_n, out_s_vld <= 0.
//   OS: acc <= acc + prod; out_s <= in_n (pass-through), out_s_vld <= 0.
//  Drain (OS, inst_w[2]=1): out_s <= acc (+prod if exec same cycle); acc <= 0; out_s_vld <= 1.
//   inst_w[2] ignored in WS. Drain has priority over pass-through of in_n for that cycle.
//  Simultaneous load+exec: exec reads slot before write (read-first); same-slot hazard returns old value.
//  Add: SAT=1 clamps to [-2^(PSUM_BW-1), 2^(PSUM_BW-1)-1]; SAT=0 wraps. Same rule for acc and out_s.
//  os_mode change with nonzero acc: acc retained; becomes visible only on next OS drain.
//  Reset mid-load/exec/drain: all state to reset values next edge; partial loads discarded.
// STRUCTURE
//  mac_pkg: INST_LOAD=0, INST_EXEC=1, INST_DRAIN=2, INST_W=3, FSM state enum {FILL,FULL}, sat_add function.
//  Sub-module mac_sat (combinational): a, w, c, sat-enable -> c + a*w with zero gate and clamp.
//  Used twice (WS psum path, OS acc path) or shared via os_mode mux; weight RF, FSM, pointers in top.
// TESTING
//  NW=4, load 4,-3,2,-1 then 5th load -> slots match; inst_e[0]=1 only on 5th-load cycle+1, out_e=5th word.
//  WS exec in_w=3 x4 cycles, in_n=10 -> out_s 22,1,16,7 (lat 1), rptr wraps, out_s_vld=1 each cycle.
//  OS exec in_w=7,7,7,7 w as above, then drain -> out_s=14 for one cycle, vld=1, acc reads 0 on 2nd drain.
//  SAT=1, PSUM_BW=8, in_n=120, prod=15*7=105 -> out_s=127; SAT=0 same stimulus -> out_s=-31.
//  in_w=0 or w=0 during exec -> zskip=1, out_s=in_n; load+exec same cycle same slot -> old weight used.
//  Assert reset mid-fill (2 of 4 slots) -> all outputs 0 next cycle, FILL, wptr=0; reload 4 words correct.

Source files
------------

// File: rtl/mac_pkg.sv
// ============================================================================
// Module : mac_pkg
// Brief  : Shared instruction-bit indices, fill FSM states and the psum adder.
// Rev    : 1.0  initial multi-weight tile release
// ============================================================================
`default_nettype none

package mac_pkg;

    localparam int INST_LOAD  = 0;
    localparam int INST_EXEC  = 1;
    localparam int INST_DRAIN = 2;
    localparam int INST_W     = 3;

    typedef enum logic [0:0] {
        ST_FILL = 1'b0,
        ST_FULL = 1'b1
    } fill_state_t;

    // Operands arrive sign-extended to 64 bits; the caller truncates to bw,
    // so the unsaturated result wraps modulo 2^bw.
    function automatic logic signed [63:0] sat_add(
        input logic signed [63:0] a,
        input logic signed [63:0] b,
        input int                 bw,
        input logic               sat
    );
        logic signed [64:0] s;
        logic signed [64:0] hi;
        logic signed [64:0] lo;
        s  = 65'(a) + 65'(b);
        hi = (65'sd1 <<< (bw - 1)) - 65'sd1;
        lo = -(65'sd1 <<< (bw - 1));
        if (sat && (s > hi))
            return hi[63:0];
        else if (sat && (s < lo))
            return lo[63:0];
        else
            return s[63:0];
    endfunction

endpackage

`default_nettype wire

// File: rtl/mac_sat.sv
// ============================================================================
// Module : mac_sat
// Brief  : Combinational y = c + a*w with zero-operand gating and optional clamp.
// Rev    : 1.0  initial multi-weight tile release
// ============================================================================
`default_nettype none

module mac_sat
    import mac_pkg::*;
#(
    parameter int BW      = 4,
    parameter int PSUM_BW = 16
) (
    input  logic                      en,
    input  logic                      sat_en,
    input  logic [BW-1:0]             a,
    input  logic signed [BW-1:0]      w,
    input  logic signed [PSUM_BW-1:0] c,
    output logic signed [PSUM_BW-1:0] y,
    output logic                      zero
);

    logic                   w_live;
    logic [BW-1:0]          w_a_g;
    logic signed [BW-1:0]   w_w_g;
    logic signed [2*BW:0]   w_prod;

    assign zero   = (a == '0) || (w == '0);
    assign w_live = en && !zero;

    // Multiplier operands are forced to zero when the product is not needed.
    assign w_a_g  = w_live ? a : '0;
    assign w_w_g  = w_live ? w : '0;
    assign w_prod = $signed({1'b0, w_a_g}) * w_w_g;

    assign y = PSUM_BW'(sat_add(64'(c), 64'(w_prod), PSUM_BW, sat_en));

endmodule

`default_nettype wire

// File: rtl/mac_tile_mw.sv
// ============================================================================
// Module : mac_tile_mw
// Brief  : Systolic PE with NW time-multiplexed weight slots, WS or OS dataflow.
// Rev    : 1.0  initial multi-weight tile release
// ============================================================================
`default_nettype none

module mac_tile_mw
    import mac_pkg::*;
#(
    parameter int BW      = 4,
    parameter int PSUM_BW = 16,
    parameter int NW      = 4,
    parameter int SAT     = 0
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      os_mode,
    input  logic [BW-1:0]             in_w,
    input  logic [INST_W-1:0]         inst_w,
    input  logic signed [PSUM_BW-1:0] in_n,
    output logic [BW-1:0]             out_e,
    output logic [INST_W-1:0]         inst_e,
    output logic signed [PSUM_BW-1:0] out_s,
    output logic                      out_s_vld,
    output logic                      zskip
);

    localparam int              c_pw   = (NW > 1) ? $clog2(NW) : 1;
    localparam logic [c_pw-1:0] c_last = c_pw'(NW - 1);

    fill_state_t               r_state, w_state_nxt;
    logic [c_pw-1:0]           r_wptr, w_wptr_nxt, w_widx, r_rptr;
    logic                      w_we, w_fill_entry, w_fwd_load, r_load_q;
    logic signed [BW-1:0]      r_w [NW];
    logic signed [PSUM_BW-1:0] r_acc, w_addend, w_sum;
    logic                      w_zero;

    logic w_load, w_exec, w_drain;
    assign w_load  = inst_w[INST_LOAD];
    assign w_exec  = inst_w[INST_EXEC];
    assign w_drain = os_mode & inst_w[INST_DRAIN];

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_FILL;
            r_wptr  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_wptr  <= w_wptr_nxt;
        end
    end

    // A fresh load burst arriving while FULL restarts the fill with slot 0.
    always_comb begin
        w_state_nxt  = r_state;
        w_wptr_nxt   = r_wptr;
        w_we         = 1'b0;
        w_widx       = r_wptr;
        w_fill_entry = 1'b0;
        w_fwd_load   = 1'b0;
        case (r_state)
            ST_FILL: begin
                if (w_load) begin
                    w_we = 1'b1;
                    if (r_wptr == c_last) begin
                        w_state_nxt = ST_FULL;
                        w_wptr_nxt  = '0;
                    end else begin
                        w_wptr_nxt  = r_wptr + 1'b1;
                    end
                end
            end
            ST_FULL: begin
                if (w_load && !r_load_q) begin
                    w_we         = 1'b1;
                    w_widx       = '0;
                    w_fill_entry = 1'b1;
                    w_state_nxt  = (c_last == '0) ? ST_FULL : ST_FILL;
                    w_wptr_nxt   = (c_last == '0) ? '0 : c_pw'(1);
                end else begin
                    w_fwd_load   = w_load;
                end
            end
            default: begin
                w_state_nxt = ST_FILL;
                w_wptr_nxt  = '0;
            end
        endcase
    end

    for (genvar g = 0; g < NW; g++) begin : g_slot
        always_ff @(posedge clk) begin
            if (reset)
                r_w[g] <= '0;
            else if (w_we && (w_widx == c_pw'(g)))
                r_w[g] <= in_w;
        end
    end

    assign w_addend = os_mode ? r_acc : in_n;

    mac_sat #(
        .BW      (BW),
        .PSUM_BW (PSUM_BW)
    ) u_mac_sat (
        .en     (w_exec),
        .sat_en (SAT != 0),
        .a      (in_w),
        .w      (r_w[r_rptr]),
        .c      (w_addend),
        .y      (w_sum),
        .zero   (w_zero)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            out_e     <= '0;
            inst_e    <= '0;
            out_s     <= '0;
            out_s_vld <= 1'b0;
            zskip     <= 1'b0;
            r_acc     <= '0;
            r_rptr    <= '0;
            r_load_q  <= 1'b0;
        end else begin
            if (w_load || w_exec)
                out_e <= in_w;
            inst_e   <= {inst_w[INST_DRAIN], inst_w[INST_EXEC], w_fwd_load};
            r_load_q <= w_load;
            if (w_exec)
                zskip <= w_zero;
            if (w_fill_entry)
                r_rptr <= '0;
            else if (w_exec)
                r_rptr <= (r_rptr == c_last) ? '0 : r_rptr + 1'b1;

            if (!os_mode) begin
                out_s     <= w_exec ? w_sum : in_n;
                out_s_vld <= w_exec;
            end else if (w_drain) begin
                out_s     <= w_sum;
                out_s_vld <= 1'b1;
                r_acc     <= '0;
            end else begin
                out_s     <= in_n;
                out_s_vld <= 1'b0;
                if (w_exec)
                    r_acc <= w_sum;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_mac_tile_mw.sv
// ============================================================================
// Module : tb_mac_tile_mw
// Brief  : Directed vector bench for mac_tile_mw (wrap and saturating builds).
// Rev    : 1.0  initial multi-weight tile release
// ============================================================================
`default_nettype none

module tb_mac_tile_mw;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        os_mode = 1'b0;
    logic [3:0]  in_w = '0;
    logic [2:0]  inst_w = '0;
    logic [15:0] in_n = '0;
    logic [3:0]  out_e;
    logic [2:0]  inst_e;
    logic [15:0] out_s;
    logic        out_s_vld;
    logic        zskip;

    logic        s_os = 1'b0;
    logic [3:0]  s_in_w = '0;
    logic [2:0]  s_inst = '0;
    logic [7:0]  s_in_n = '0;
    logic [3:0]  sa_out_e, wa_out_e;
    logic [2:0]  sa_inst_e, wa_inst_e;
    logic [7:0]  sa_out_s, wa_out_s;
    logic        sa_vld, wa_vld, sa_zskip, wa_zskip;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mac_tile_mw #(.BW(4), .PSUM_BW(16), .NW(4), .SAT(0)) dut (
        .clk(clk), .reset(reset), .os_mode(os_mode), .in_w(in_w), .inst_w(inst_w),
        .in_n(in_n), .out_e(out_e), .inst_e(inst_e), .out_s(out_s),
        .out_s_vld(out_s_vld), .zskip(zskip)
    );

    mac_tile_mw #(.BW(4), .PSUM_BW(8), .NW(1), .SAT(1)) dut_sat (
        .clk(clk), .reset(reset), .os_mode(s_os), .in_w(s_in_w), .inst_w(s_inst),
        .in_n(s_in_n), .out_e(sa_out_e), .inst_e(sa_inst_e), .out_s(sa_out_s),
        .out_s_vld(sa_vld), .zskip(sa_zskip)
    );

    mac_tile_mw #(.BW(4), .PSUM_BW(8), .NW(1), .SAT(0)) dut_wrap (
        .clk(clk), .reset(reset), .os_mode(s_os), .in_w(s_in_w), .inst_w(s_inst),
        .in_n(s_in_n), .out_e(wa_out_e), .inst_e(wa_inst_e), .out_s(wa_out_s),
        .out_s_vld(wa_vld), .zskip(wa_zskip)
    );

    typedef struct {
        logic [2:0]  inst;
        logic        os;
        logic [3:0]  in_w;
        logic [15:0] in_n;
        logic [3:0]  e_out_e;
        logic [2:0]  e_inst_e;
        logic [15:0] e_out_s;
        logic        e_vld;
        logic        e_zskip;
    } vec_t;

    vec_t vt [33];

    function automatic vec_t mk(input logic [2:0] inst, input logic os, input int iw,
                                input int inn, input int oe, input logic [2:0] ie,
                                input int os_exp, input logic vld, input logic zs);
        vec_t v;
        v.inst = inst; v.os = os; v.in_w = 4'(iw); v.in_n = 16'(inn);
        v.e_out_e = 4'(oe); v.e_inst_e = ie; v.e_out_s = 16'(os_exp);
        v.e_vld = vld; v.e_zskip = zs;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [2:0] inst, input logic os, input logic [3:0] iw,
                         input logic [15:0] inn);
        @(negedge clk);
        inst_w = inst; os_mode = os; in_w = iw; in_n = inn;
        @(posedge clk);
        #1;
    endtask

    task automatic check_all(input string tag, input logic [3:0] oe, input logic [2:0] ie,
                             input logic [15:0] os_exp, input logic vld, input logic zs);
        chk({tag, ".out_e"}, 32'(out_e), 32'(oe));
        chk({tag, ".inst_e"}, 32'(inst_e), 32'(ie));
        chk({tag, ".out_s"}, 32'(out_s), 32'(os_exp));
        chk({tag, ".vld"}, 32'(out_s_vld), 32'(vld));
        chk({tag, ".zskip"}, 32'(zskip), 32'(zs));
    endtask

    task automatic sat_step(input logic [2:0] inst, input logic [3:0] iw, input logic [7:0] inn);
        @(negedge clk);
        s_inst = inst; s_in_w = iw; s_in_n = inn; s_os = 1'b0;
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Weights 4,-3,2,-1 then a continuous 5th load that must be forwarded east.
        vt[0]  = mk(3'b001, 0, 4,   10, 4,   3'b000, 10, 0, 0);
        vt[1]  = mk(3'b001, 0, 13,  10, 13,  3'b000, 10, 0, 0);
        vt[2]  = mk(3'b001, 0, 2,   10, 2,   3'b000, 10, 0, 0);
        vt[3]  = mk(3'b001, 0, 15,  10, 15,  3'b000, 10, 0, 0);
        vt[4]  = mk(3'b001, 0, 5,   10, 5,   3'b001, 10, 0, 0);
        vt[5]  = mk(3'b010, 0, 3,   10, 3,   3'b010, 22, 1, 0);
        vt[6]  = mk(3'b010, 0, 3,   10, 3,   3'b010, 1,  1, 0);
        vt[7]  = mk(3'b010, 0, 3,   10, 3,   3'b010, 16, 1, 0);
        vt[8]  = mk(3'b010, 0, 3,   10, 3,   3'b010, 7,  1, 0);
        vt[9]  = mk(3'b010, 0, 3,   10, 3,   3'b010, 22, 1, 0);
        vt[10] = mk(3'b000, 0, 9,   -5, 3,   3'b000, -5, 0, 0);
        vt[11] = mk(3'b010, 0, 0,   10, 0,   3'b010, 10, 1, 1);
        vt[12] = mk(3'b010, 1, 7,   33, 7,   3'b010, 33, 0, 0);
        vt[13] = mk(3'b010, 1, 7,   33, 7,   3'b010, 33, 0, 0);
        vt[14] = mk(3'b010, 1, 7,   33, 7,   3'b010, 33, 0, 0);
        vt[15] = mk(3'b010, 1, 7,   33, 7,   3'b010, 33, 0, 0);
        vt[16] = mk(3'b100, 1, 1,   33, 7,   3'b100, 14, 1, 0);
        vt[17] = mk(3'b000, 1, 1,   33, 7,   3'b000, 33, 0, 0);
        vt[18] = mk(3'b100, 1, 1,   33, 7,   3'b100, 0,  1, 0);
        vt[19] = mk(3'b100, 0, 1,   44, 7,   3'b100, 44, 0, 0);
        vt[20] = mk(3'b010, 1, 2,   5,  2,   3'b010, 5,  0, 0);
        vt[21] = mk(3'b010, 0, 1,   100, 1,  3'b010, 99, 1, 0);
        vt[22] = mk(3'b110, 1, 1,   0,  1,   3'b110, 8,  1, 0);
        vt[23] = mk(3'b010, 0, 1,   0,  1,   3'b010, -3, 1, 0);
        vt[24] = mk(3'b010, 0, 1,   0,  1,   3'b010, 2,  1, 0);
        vt[25] = mk(3'b010, 0, 1,   0,  1,   3'b010, -1, 1, 0);
        // Reload burst with exec: slot 0 read-before-write, then a zero weight.
        vt[26] = mk(3'b011, 0, 6,   0,  6,   3'b010, 24, 1, 0);
        vt[27] = mk(3'b011, 0, 0,   0,  0,   3'b010, 0,  1, 1);
        vt[28] = mk(3'b011, 0, 1,   7,  1,   3'b010, 7,  1, 1);
        vt[29] = mk(3'b011, 0, 2,   0,  2,   3'b010, 2,  1, 0);
        vt[30] = mk(3'b010, 0, 3,   0,  3,   3'b010, 6,  1, 0);
        vt[31] = mk(3'b010, 0, 3,   0,  3,   3'b010, 18, 1, 0);
        vt[32] = mk(3'b000, 0, 0,   0,  3,   3'b000, 0,  0, 0);

        reset = 1'b1;
        @(posedge clk);
        #1;
        check_all("reset", 4'd0, 3'b000, 16'd0, 1'b0, 1'b0);
        @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < 33; i++) begin
            drive(vt[i].inst, vt[i].os, vt[i].in_w, vt[i].in_n);
            check_all($sformatf("vec%0d", i), vt[i].e_out_e, vt[i].e_inst_e,
                      vt[i].e_out_s, vt[i].e_vld, vt[i].e_zskip);
        end

        // Reset in the middle of a fill: two words loaded, then reset with a load pending.
        drive(3'b001, 0, 4'd1, 16'd0);
        drive(3'b001, 0, 4'd1, 16'd0);
        @(negedge clk);
        reset = 1'b1; inst_w = 3'b001; in_w = 4'd9; in_n = 16'd50; os_mode = 1'b0;
        @(posedge clk);
        #1;
        check_all("midreset", 4'd0, 3'b000, 16'd0, 1'b0, 1'b0);
        @(negedge clk);
        reset = 1'b0; inst_w = 3'b000;
        for (int i = 1; i <= 4; i++)
            drive(3'b001, 0, 4'(i), 16'd0);
        for (int i = 1; i <= 4; i++) begin
            drive(3'b010, 0, 4'd1, 16'd0);
            chk($sformatf("reload_exec%0d.out_s", i), 32'(out_s), 32'(i));
            chk($sformatf("reload_exec%0d.vld", i), 32'(out_s_vld), 32'd1);
        end
        drive(3'b000, 0, 4'd0, 16'd0);

        // Saturating vs wrapping adders, PSUM_BW=8, single weight slot.
        sat_step(3'b001, 4'd7, 8'd0);
        sat_step(3'b010, 4'd15, 8'd120);
        chk("sat_pos.out_s", 32'(sa_out_s), 32'(8'd127));
        chk("wrap_pos.out_s", 32'(wa_out_s), 32'(8'hE1));
        chk("sat_pos.vld", 32'(sa_vld), 32'd1);
        sat_step(3'b001, 4'h8, 8'd0);
        sat_step(3'b010, 4'd15, 8'h88);
        chk("sat_neg.out_s", 32'(sa_out_s), 32'(8'h80));
        chk("wrap_neg.out_s", 32'(wa_out_s), 32'(8'd16));
        chk("wrap_neg.vld", 32'(wa_vld), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
